// File: rtl/audio_dsm_dac.sv
// rtl/audio_dsm_dac.sv - DC blocker, volume shift and second-order delta-sigma 1-bit audio DAC
module audio_dsm_dac #(
    parameter int DC_SHIFT = 10,
    parameter int CLAMP1   = 18,
    parameter int CLAMP2   = 22
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cen,
    input  logic [15:0] sample_in,
    input  logic        dc_bypass,
    input  logic [2:0]  vol,
    input  logic        mute,
    output logic        dac_out,
    output logic        clip
);
    localparam int AW = 18 + DC_SHIFT;
    localparam logic signed [AW-1:0] S16_MAX = AW'(32767);
    localparam logic signed [AW-1:0] S16_MIN = AW'(-32768);
    localparam logic signed [24:0]   C1_MAX  = 25'((1 << CLAMP1) - 1);
    localparam logic signed [24:0]   C1_MIN  = 25'(-(1 << CLAMP1));
    localparam logic signed [24:0]   C2_MAX  = 25'((1 << CLAMP2) - 1);
    localparam logic signed [24:0]   C2_MIN  = 25'(-(1 << CLAMP2));

    logic [15:0]          sample_reg;
    logic                 a_vld;
    logic                 b_vld;
    logic signed [AW-1:0] dc_acc;
    logic signed [15:0]   y;
    logic signed [15:0]   v;
    logic signed [19:0]   int1;
    logic signed [23:0]   int2;

    logic signed [17:0]   x;
    logic signed [AW-1:0] x_w;
    logic signed [AW-1:0] d;
    logic signed [AW-1:0] blk;
    logic                 sat_hi;
    logic                 sat_lo;
    logic signed [15:0]   y_next;

    // Offset-binary to two's complement, then leaky DC removal
    assign x      = $signed({2'b00, sample_reg} - 18'd32768);
    assign x_w    = {{(AW-18){x[17]}}, x};
    assign d      = x_w - (dc_acc >>> DC_SHIFT);
    assign blk    = dc_bypass ? x_w : d;
    assign sat_hi = blk > S16_MAX;
    assign sat_lo = blk < S16_MIN;
    assign y_next = sat_hi ? 16'h7fff : (sat_lo ? 16'h8000 : blk[15:0]);

    logic signed [24:0] fb;
    logic signed [24:0] v_w;
    logic signed [24:0] i1_w;
    logic signed [24:0] i2_w;
    logic signed [24:0] s1;
    logic signed [24:0] s2;
    logic               c1_hi;
    logic               c1_lo;
    logic               c2_hi;
    logic               c2_lo;
    logic signed [19:0] n1;
    logic signed [23:0] n2;

    // Both integrators are summed at 25 bits so the clamp sees the true value
    assign fb    = dac_out ? 25'sd32767 : -25'sd32768;
    assign v_w   = {{9{v[15]}}, v};
    assign i1_w  = {{5{int1[19]}}, int1};
    assign i2_w  = {{1{int2[23]}}, int2};
    assign s1    = i1_w + v_w - fb;
    assign s2    = i2_w + i1_w - fb;
    assign c1_hi = s1 > C1_MAX;
    assign c1_lo = s1 < C1_MIN;
    assign c2_hi = s2 > C2_MAX;
    assign c2_lo = s2 < C2_MIN;
    assign n1    = c1_hi ? C1_MAX[19:0] : (c1_lo ? C1_MIN[19:0] : s1[19:0]);
    assign n2    = c2_hi ? C2_MAX[23:0] : (c2_lo ? C2_MIN[23:0] : s2[23:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            sample_reg <= '0;
            a_vld      <= 1'b0;
            b_vld      <= 1'b0;
            dc_acc     <= '0;
            y          <= '0;
            v          <= '0;
            int1       <= '0;
            int2       <= '0;
            dac_out    <= 1'b0;
            clip       <= 1'b0;
        end else begin
            a_vld <= cen;
            if (cen) begin
                sample_reg <= sample_in;
            end
            b_vld <= a_vld;
            if (a_vld) begin
                y <= y_next;
                if (!dc_bypass) begin
                    dc_acc <= dc_acc + d;
                end
            end
            if (b_vld) begin
                v <= mute ? 16'sd0 : (y >>> vol);
            end
            int1    <= n1;
            int2    <= n2;
            dac_out <= ~n2[23];
            clip    <= (a_vld & (sat_hi | sat_lo)) | c1_hi | c1_lo | c2_hi | c2_lo;
        end
    end
endmodule

// File: tb/tb_audio_dsm_dac.sv
// tb/tb_audio_dsm_dac.sv - directed self-checking bench for audio_dsm_dac
module tb_audio_dsm_dac;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cen = 1'b0;
    logic [15:0] sample_in = 16'h8000;
    logic        dc_bypass = 1'b1;
    logic [2:0]  vol = 3'd0;
    logic        mute = 1'b0;
    logic        dac_out;
    logic        clip;

    int tests = 0;
    int fails = 0;
    int ones;

    audio_dsm_dac #(.DC_SHIFT(4), .CLAMP1(18), .CLAMP2(22)) dut (
        .clock     (clock),
        .reset     (reset),
        .cen       (cen),
        .sample_in (sample_in),
        .dc_bypass (dc_bypass),
        .vol       (vol),
        .mute      (mute),
        .dac_out   (dac_out),
        .clip      (clip)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Free-run n clocks with cen every 4th cycle, counting ones on dac_out
    task automatic run_ones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cen = (i % 4 == 0);
            tick();
            cnt += int'(dac_out);
        end
        cen = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic strobe();
        cen = 1'b1;
        tick();
        cen = 1'b0;
    endtask

    initial begin
        // Reset held 4 cycles, midscale input
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_dac", dac_out, 0);
            check("rst_clip", clip, 0);
        end
        check("rst_sample_reg", dut.sample_reg, 0);
        check("rst_int1", dut.int1, 0);
        check("rst_int2", dut.int2, 0);
        reset = 1'b0;
        run_ones(8192, ones);
        check_rng("mid_density", ones, 4080, 4112);

        // Positive full scale, bypass, vol 0
        pulse_reset();
        sample_in = 16'hffff;
        run_ones(64, ones);
        check("fs_v", dut.v, 32767);
        run_ones(4096, ones);
        check_rng("fs_density", ones, 4055, 4096);

        // vol=2 latency and density
        pulse_reset();
        vol = 3'd2;
        strobe();
        check("lat_sample_reg", dut.sample_reg, 16'hffff);
        check("lat_v_t0", dut.v, 0);
        tick();
        check("lat_v_t1", dut.v, 0);
        tick();
        check("lat_v_t2", dut.v, 8191);
        run_ones(64, ones);
        run_ones(4096, ones);
        check_rng("vol2_density", ones, 2478, 2642);

        // cen held low: nothing moves, vol change ignored until next update
        vol = 3'd0;
        for (int i = 0; i < 100; i++) begin
            sample_in = 16'($urandom);
            tick();
        end
        check("hold_sample_reg", dut.sample_reg, 16'hffff);
        check("hold_v", dut.v, 8191);
        sample_in = 16'h8000;
        strobe();
        tick();
        check("single_cen_t1", dut.v, 8191);
        tick();
        check("single_cen_t2", dut.v, 0);

        sample_in = 16'hffff;
        mute = 1'b1;
        strobe();
        tick();
        tick();
        check("mute_v", dut.v, 0);
        mute = 1'b0;

        // DC blocker, DC_SHIFT=4, 0xC000 constant
        pulse_reset();
        dc_bypass = 1'b0;
        sample_in = 16'hc000;
        strobe();
        tick();
        tick();
        check("dc_first_v", dut.v, 16384);
        strobe();
        tick();
        tick();
        check("dc_second_v", dut.v, 15360);
        run_ones(8000, ones);
        check("dc_acc_settled", dut.dc_acc, 262144);
        check("dc_v_settled", dut.v, 0);
        run_ones(4096, ones);
        check_rng("dc_density", ones, 1966, 2130);

        // Step to 0x0000 overdrives the blocker output -> sat16 clamp
        sample_in = 16'h0000;
        strobe();
        tick();
        check("sat_clip", clip, 1);
        check("sat_y", dut.y, -32768);
        check("sat_dc_acc", dut.dc_acc, 212992);
        tick();
        check("sat_v", dut.v, -32768);

        // Mid-stream reset with cen asserted in the same cycle
        dc_bypass = 1'b1;
        sample_in = 16'hffff;
        run_ones(200, ones);
        reset = 1'b1;
        cen = 1'b1;
        tick();
        reset = 1'b0;
        cen = 1'b0;
        check("mrst_int1", dut.int1, 0);
        check("mrst_int2", dut.int2, 0);
        check("mrst_dac", dac_out, 0);
        check("mrst_dc_acc", dut.dc_acc, 0);
        check("mrst_v", dut.v, 0);
        check("mrst_sample_reg", dut.sample_reg, 0);
        check("mrst_clip", clip, 0);
        tick();
        check("resume_int1", dut.int1, 32768);
        check("resume_int2", dut.int2, 32768);
        check("resume_dac", dac_out, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
